axi_slave_mem: RTL and testbench

//  AXI-style slave endpoint holding a small register-file memory; the responder end of the team's
//  axi_master five-channel interface (AW, WD, B, RA, RD). Accepts one write (address + data) and one

---
 rtl/axi_slave_mem.sv | 180 ++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI-style slave endpoint backed by a small register-file memory.
// Independent write (AW/WD -> B) and read (RA -> RD) FSMs, so reads and writes overlap freely.
module axi_slave_mem #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 64,
    parameter int DEPTH    = 16,
    parameter int ADDR_LSB = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] out_write_address,
    input  logic              WDVALID,
    output logic              WDREADY,
    input  logic [DATA_W-1:0] out_write_data,
    input  logic              BVALID,
    output logic              BREADY,
    output logic              BRESP,
    input  logic              RAVALID,
    output logic              RAREADY,
    input  logic [ADDR_W-1:0] out_read_address,
    output logic              RDVALID,
    input  logic              RDREADY,
    output logic [DATA_W-1:0] out_read_data
);

    localparam int IDX_W  = ADDR_W - ADDR_LSB;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [1:0]        r_wstate;
    logic [1:0]        r_rstate;
    logic              r_aw_done;
    logic              r_wd_done;
    logic [IDX_W-1:0]  r_widx;
    logic [IDX_W-1:0]  r_ridx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_aw_hs;
    logic w_wd_hs;
    logic w_b_hs;
    logic w_ra_hs;
    logic w_aw_done_nx;
    logic w_wd_done_nx;
    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_unused_addr_bits;

    assign w_aw_hs       = AWVALID && AWREADY;
    assign w_wd_hs       = WDVALID && WDREADY;
    assign w_b_hs        = BVALID && BREADY;
    assign w_ra_hs       = RAVALID && RAREADY;
    assign w_aw_done_nx  = r_aw_done || w_aw_hs;
    assign w_wd_done_nx  = r_wd_done || w_wd_hs;
    assign w_wr_in_range = (r_widx < DEPTH_IDX);
    assign w_rd_in_range = (r_ridx < DEPTH_IDX);

    // Byte-offset bits never select anything.
    assign w_unused_addr_bits = ^{out_write_address[ADDR_LSB-1:0], out_read_address[ADDR_LSB-1:0]};

    // Memory array: cleared on reset, written only in the commit cycle of an in-range write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_wstate == W_COMMIT) && w_wr_in_range) begin
            r_mem[r_widx[MEM_AW-1:0]] <= r_wdata;
        end
    end

    // Write FSM: collect AW and WD in any order, commit, then hold the response until BVALID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wstate  <= W_IDLE;
            r_aw_done <= 1'b0;
            r_wd_done <= 1'b0;
            r_widx    <= '0;
            r_wdata   <= '0;
            AWREADY   <= 1'b0;
            WDREADY   <= 1'b0;
            BREADY    <= 1'b0;
            BRESP     <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_widx <= out_write_address[ADDR_W-1:ADDR_LSB];
                    end
                    if (w_wd_hs) begin
                        r_wdata <= out_write_data;
                    end
                    r_aw_done <= w_aw_done_nx;
                    r_wd_done <= w_wd_done_nx;
                    AWREADY   <= !w_aw_done_nx;
                    WDREADY   <= !w_wd_done_nx;
                    if (w_aw_done_nx && w_wd_done_nx) begin
                        r_wstate <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    BRESP    <= w_wr_in_range;
                    BREADY   <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        BREADY    <= 1'b0;
                        BRESP     <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_wd_done <= 1'b0;
                        AWREADY   <= 1'b1;
                        WDREADY   <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_aw_done <= 1'b0;
                    r_wd_done <= 1'b0;
                    AWREADY   <= 1'b0;
                    WDREADY   <= 1'b0;
                    BREADY    <= 1'b0;
                    BRESP     <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: latch address, fetch (pre-write data on a same-cycle commit), hold until RDREADY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rstate      <= R_IDLE;
            r_ridx        <= '0;
            RAREADY       <= 1'b0;
            RDVALID       <= 1'b0;
            out_read_data <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ra_hs) begin
                        r_ridx   <= out_read_address[ADDR_W-1:ADDR_LSB];
                        RAREADY  <= 1'b0;
                        r_rstate <= R_FETCH;
                    end else begin
                        RAREADY  <= 1'b1;
                    end
                end
                R_FETCH: begin
                    out_read_data <= w_rd_in_range ? r_mem[r_ridx[MEM_AW-1:0]] : '0;
                    RDVALID       <= 1'b1;
                    r_rstate      <= R_DATA;
                end
                R_DATA: begin
                    if (RDREADY) begin
                        RDVALID  <= 1'b0;
                        RAREADY  <= 1'b1;
                        r_rstate <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                    RAREADY  <= 1'b0;
                    RDVALID  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: hand-computed expectations for write, read, range,
// ordering, backpressure, collision and asynchronous reset behaviour.
module tb_axi_slave_mem;

    logic         clk;
    logic         reset;
    logic         AWVALID;
    logic         AWREADY;
    logic [63:0]  out_write_address;
    logic         WDVALID;
    logic         WDREADY;
    logic [127:0] out_write_data;
    logic         BVALID;
    logic         BREADY;
    logic         BRESP;
    logic         RAVALID;
    logic         RAREADY;
    logic [63:0]  out_read_address;
    logic         RDVALID;
    logic         RDREADY;
    logic [127:0] out_read_data;

    int n_vec;
    int n_miss;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_5A = {16{8'h5A}};
    localparam logic [127:0] PAT_C3 = {16{8'hC3}};

    axi_slave_mem dut (
        .clk               (clk),
        .reset             (reset),
        .AWVALID           (AWVALID),
        .AWREADY           (AWREADY),
        .out_write_address (out_write_address),
        .WDVALID           (WDVALID),
        .WDREADY           (WDREADY),
        .out_write_data    (out_write_data),
        .BVALID            (BVALID),
        .BREADY            (BREADY),
        .BRESP             (BRESP),
        .RAVALID           (RAVALID),
        .RAREADY           (RAREADY),
        .out_read_address  (out_read_address),
        .RDVALID           (RDVALID),
        .RDREADY           (RDREADY),
        .out_read_data     (out_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write with BVALID already high: response completes one edge after BREADY rises.
    task automatic do_write(input string tag, input logic [63:0] addr, input logic [127:0] data,
                            input logic exp_resp);
        AWVALID = 1'b1; out_write_address = addr;
        WDVALID = 1'b1; out_write_data = data;
        BVALID  = 1'b1;
        tick();
        AWVALID = 1'b0; WDVALID = 1'b0;
        out_write_address = 64'hDEAD_BEEF_0000_0000;
        check_val({tag, "_bready_hs"}, {127'd0, BREADY}, 128'd0);
        tick();
        check_val({tag, "_bready"}, {127'd0, BREADY}, 128'd1);
        check_val({tag, "_bresp"}, {127'd0, BRESP}, {127'd0, exp_resp});
        tick();
        check_val({tag, "_bdone"}, {127'd0, BREADY}, 128'd0);
        BVALID = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [63:0] addr, input logic [127:0] exp);
        RAVALID = 1'b1; out_read_address = addr; RDREADY = 1'b0;
        tick();
        RAVALID = 1'b0; out_read_address = 64'hFFFF_FFFF_FFFF_FFFF;
        check_val({tag, "_rdvalid_hs"}, {127'd0, RDVALID}, 128'd0);
        tick();
        check_val({tag, "_rdvalid"}, {127'd0, RDVALID}, 128'd1);
        check_val({tag, "_rdata"}, out_read_data, exp);
        RDREADY = 1'b1;
        tick();
        check_val({tag, "_rddone"}, {127'd0, RDVALID}, 128'd0);
        RDREADY = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        reset = 1'b0;
        AWVALID = 1'b0; WDVALID = 1'b0; BVALID = 1'b0; RAVALID = 1'b0; RDREADY = 1'b0;
        out_write_address = 64'd0; out_write_data = 128'd0; out_read_address = 64'd0;
        repeat (3) tick();
        check_val("rst_outs", {122'd0, AWREADY, WDREADY, BREADY, BRESP, RAREADY, RDVALID}, 128'd0);
        check_val("rst_rdata", out_read_data, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_val("idle_readies", {125'd0, AWREADY, WDREADY, RAREADY}, 128'h7);

        // Same-cycle AW/WD to word 2.
        do_write("wr20", 64'h20, PAT_A5, 1'b1);
        check_val("wr20_readies", {126'd0, AWREADY, WDREADY}, 128'h3);

        // Read back with RDREADY held low for five cycles.
        RAVALID = 1'b1; out_read_address = 64'h20;
        tick();
        RAVALID = 1'b0;
        check_val("rd20_raready", {127'd0, RAREADY}, 128'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val("rd20_hold_valid", {127'd0, RDVALID}, 128'd1);
            check_val("rd20_hold_data", out_read_data, PAT_A5);
            tick();
        end
        RDREADY = 1'b1;
        tick();
        RDREADY = 1'b0;
        check_val("rd20_drop", {127'd0, RDVALID}, 128'd0);
        check_val("rd20_data_kept", out_read_data, PAT_A5);
        check_val("rd20_raready_back", {127'd0, RAREADY}, 128'd1);

        // Out-of-range write with BVALID stalled low.
        AWVALID = 1'b1; out_write_address = 64'h100;
        WDVALID = 1'b1; out_write_data = 128'h1234;
        tick();
        tick();
        check_val("oor_bready", {127'd0, BREADY}, 128'd1);
        check_val("oor_bresp", {127'd0, BRESP}, 128'd0);
        repeat (3) tick();
        check_val("oor_stall_bready", {127'd0, BREADY}, 128'd1);
        check_val("oor_stall_readies", {126'd0, AWREADY, WDREADY}, 128'd0);
        AWVALID = 1'b0; WDVALID = 1'b0;
        BVALID = 1'b1;
        tick();
        BVALID = 1'b0;
        check_val("oor_bdone", {127'd0, BREADY}, 128'd0);
        do_read("rd100", 64'h100, 128'd0);
        do_read("rd00", 64'h00, 128'd0);
        do_read("rd20_again", 64'h20, PAT_A5);

        // WD arrives three cycles before AW.
        WDVALID = 1'b1; out_write_data = PAT_5A;
        tick();
        WDVALID = 1'b0; out_write_data = 128'd0;
        check_val("wdfirst_wdready", {127'd0, WDREADY}, 128'd0);
        check_val("wdfirst_awready", {127'd0, AWREADY}, 128'd1);
        tick(); tick();
        check_val("wdfirst_wait", {127'd0, BREADY}, 128'd0);
        AWVALID = 1'b1; out_write_address = 64'h3C;
        BVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check_val("wdfirst_awready_drop", {127'd0, AWREADY}, 128'd0);
        tick();
        check_val("wdfirst_bready", {128'd0} | {127'd0, BREADY} | {126'd0, BRESP, 1'b0}, 128'h3);
        tick();
        BVALID = 1'b0;
        do_read("rd30", 64'h30, PAT_5A);

        // Same-word write and read in the same cycle: read sees the old contents.
        AWVALID = 1'b1; out_write_address = 64'h30;
        WDVALID = 1'b1; out_write_data = PAT_C3;
        RAVALID = 1'b1; out_read_address = 64'h30;
        BVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WDVALID = 1'b0; RAVALID = 1'b0;
        tick();
        check_val("coll_rdata_old", out_read_data, PAT_5A);
        RDREADY = 1'b1;
        tick();
        RDREADY = 1'b0;
        BVALID = 1'b0;
        do_read("coll_after", 64'h30, PAT_C3);

        // Reset while both FSMs are mid-transaction.
        AWVALID = 1'b1; out_write_address = 64'h40;
        WDVALID = 1'b1; out_write_data = 128'h77;
        RAVALID = 1'b1; out_read_address = 64'h20;
        tick();
        AWVALID = 1'b0; WDVALID = 1'b0; RAVALID = 1'b0;
        tick();
        check_val("prerst_busy", {126'd0, BREADY, RDVALID}, 128'h3);
        #2;
        reset = 1'b0;
        #1;
        check_val("midrst_outs", {122'd0, AWREADY, WDREADY, BREADY, BRESP, RAREADY, RDVALID}, 128'd0);
        check_val("midrst_rdata", out_read_data, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        do_read("postrst20", 64'h20, 128'd0);
        do_read("postrst40", 64'h40, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
